// File: rtl/glogic_pipe.sv
// Registered multi-function bitwise logic unit with valid/ready handshake and accumulate mode.
// Optional zero-result flag is enabled by defining GLOGIC_ZFLAG_EN.
module glogic_pipe #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  input  logic               acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic [COUNT_W-1:0] count
`ifdef GLOGIC_ZFLAG_EN
  ,
  output logic               zero
`endif
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             consume;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  always_comb begin
    opnd_a = acc ? acc_reg : a;
    result = '0;
    unique case (op_e'(op))
      OP_AND:  result = opnd_a & b;
      OP_OR:   result = opnd_a | b;
      OP_XOR:  result = opnd_a ^ b;
      OP_NAND: result = ~(opnd_a & b);
      OP_NOR:  result = ~(opnd_a | b);
      OP_XNOR: result = ~(opnd_a ^ b);
      OP_ANDN: result = opnd_a & ~b;
      OP_PASS: result = b;
      default: result = '0;
    endcase
  end

  // Accept takes precedence over consume so a simultaneous pair keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      acc_reg   <= '0;
      count     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= result;
      acc_reg   <= result;
      count     <= count + COUNT_W'(1);
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GLOGIC_ZFLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero <= 1'b0;
    end else if (accept) begin
      zero <= (result == '0);
    end
  end
`endif

endmodule
